// File: rtl/ncl_dr_reg_stage.sv
`default_nettype none
// ============================================================================
// Module   : ncl_dr_reg_stage
// Purpose  : Clocked functional model of a NCL dual-rail register stage.
//            Each rail is a TH22 gate with the downstream acknowledge ki:
//            it sets when both inputs are high, clears when both are low,
//            and otherwise holds. A stage-wide completion detector drives
//            ko with hysteresis, so partial wavefronts never toggle it.
//            One rising clock edge is one gate-evaluation step.
// Ports    : clk     - evaluation clock, rising edge
//            rst_n   - asynchronous active-low reset
//            d_t/d_f - upstream true/false rails   [WIDTH]
//            ki      - downstream ack (1 = request DATA, 0 = request NULL)
//            q_t/q_f - registered true/false rails [WIDTH]
//            ko      - upstream ack (1 = ready for DATA, 0 = ready for NULL)
//            wf_cnt  - completed DATA wavefront count [CNT_W], wraps
//            err     - sticky illegal-code flag
// Options  : NCL_DR_REG_ILLEGAL_CHK_EN - when defined, an input bit with both
//            rails high sets err and that bit's rails hold for the edge.
//            When undefined, err is tied low and rails follow pure TH22.
// Revision : 1.0 - initial release
// ============================================================================
module ncl_dr_reg_stage #(
    parameter int WIDTH    = 4,
    parameter int RST_DATA = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_t,
    input  logic [WIDTH-1:0] d_f,
    input  logic             ki,
    output logic [WIDTH-1:0] q_t,
    output logic [WIDTH-1:0] q_f,
    output logic             ko,
    output logic [CNT_W-1:0] wf_cnt,
    output logic             err
);

    // Reset wavefront: NULL, or DATA0 (all false rails high) so a ring can
    // be seeded with a token. ko at reset reflects that wavefront.
    localparam logic [WIDTH-1:0] c_q_f_rst = (RST_DATA != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic             c_ko_rst  = (RST_DATA != 0) ? 1'b0 : 1'b1;

    logic [WIDTH-1:0] r_q_t;
    logic [WIDTH-1:0] r_q_f;
    logic             r_ko;
    logic [CNT_W-1:0] r_wf_cnt;

    logic [WIDTH-1:0] w_q_t_nxt;
    logic [WIDTH-1:0] w_q_f_nxt;
    logic [WIDTH-1:0] w_hold;
    logic             w_all_data;
    logic             w_all_null;
    logic             w_ko_nxt;
    logic             w_cnt_inc;

`ifdef NCL_DR_REG_ILLEGAL_CHK_EN
    // Both rails high on one bit is not a legal NCL code; freeze that bit so
    // the illegal code never reaches the registered rails.
    assign w_hold = d_t & d_f;
`else
    assign w_hold = {WIDTH{1'b0}};
`endif

    // Per-bit TH22 evaluation, independent for every rail.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_rail
            assign w_q_t_nxt[i] = w_hold[i]          ? r_q_t[i] :
                                  (d_t[i] & ki)      ? 1'b1     :
                                  (!d_t[i] && !ki)   ? 1'b0     : r_q_t[i];
            assign w_q_f_nxt[i] = w_hold[i]          ? r_q_f[i] :
                                  (d_f[i] & ki)      ? 1'b1     :
                                  (!d_f[i] && !ki)   ? 1'b0     : r_q_f[i];
        end
    endgenerate

    // Completion is taken from the registered rails, adding one cycle of
    // latency between q and ko.
    assign w_all_data = &(r_q_t | r_q_f);
    assign w_all_null = ~|(r_q_t | r_q_f);

    // THnn hysteresis: only a complete wavefront of either kind moves ko.
    assign w_ko_nxt  = w_all_data ? 1'b0 : (w_all_null ? 1'b1 : r_ko);

    // A DATA wavefront is counted on the edge where ko falls.
    assign w_cnt_inc = r_ko & w_all_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_t    <= {WIDTH{1'b0}};
            r_q_f    <= c_q_f_rst;
            r_ko     <= c_ko_rst;
            r_wf_cnt <= {CNT_W{1'b0}};
        end else begin
            r_q_t    <= w_q_t_nxt;
            r_q_f    <= w_q_f_nxt;
            r_ko     <= w_ko_nxt;
            if (w_cnt_inc) begin
                r_wf_cnt <= r_wf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef NCL_DR_REG_ILLEGAL_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (|w_hold) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign q_t    = r_q_t;
    assign q_f    = r_q_f;
    assign ko     = r_ko;
    assign wf_cnt = r_wf_cnt;

endmodule
`default_nettype wire
